// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - multi-cycle data-memory responder for MEM-stage loads and stores
module dm_responder #(
   parameter int ADDR_WIDTH = 12,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_width,
   input  logic        req_extend,
   input  logic [31:0] req_wd,
   output logic        resp_valid,
   output logic [31:0] resp_rd,
   output logic        resp_err
);

   localparam int          DEPTH    = 1 << ADDR_WIDTH;
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   localparam logic [1:0]  W_WORD = 2'b00;
   localparam logic [1:0]  W_HALF = 2'b01;
   localparam logic [1:0]  W_BYTE = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_RESP
   } state_t;

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic                    we_q, we_d;
   logic [ADDR_WIDTH+1:0]   addr_q, addr_d;
   logic [1:0]              width_q, width_d;
   logic                    extend_q, extend_d;
   logic [31:0]             wd_q, wd_d;
   logic [31:0]             resp_rd_q, resp_rd_d;
   logic                    resp_err_q, resp_err_d;

   logic [31:0]             mem [DEPTH];

   logic [ADDR_WIDTH-1:0]   word_idx;
   logic [31:0]             rd_word;
   logic [4:0]              lane_sh;
   logic [31:0]             lane_mask;
   logic [31:0]             lane_word;
   logic [31:0]             load_data;
   logic [31:0]             wr_word;
   logic                    acc_err;
   logic                    mem_we;

   // Address bits above the RAM index are intentionally ignored so addresses wrap.
   logic unused_addr_hi;
   assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = (state_q == S_RESP);
   assign resp_rd    = resp_rd_q;
   assign resp_err   = resp_err_q;

   assign word_idx = addr_q[ADDR_WIDTH+1:2];
   assign rd_word  = mem[word_idx];

   // Decode lane position, alignment errors, load extraction and store merge for the latched request.
   always_comb begin
      acc_err   = 1'b0;
      lane_sh   = 5'd0;
      lane_mask = 32'hFFFF_FFFF;
      case (width_q)
         W_WORD: begin
            acc_err = (addr_q[1:0] != 2'b00);
         end
         W_HALF: begin
            acc_err   = addr_q[0];
            lane_sh   = {addr_q[1], 4'b0000};
            lane_mask = 32'h0000_FFFF << lane_sh;
         end
         W_BYTE: begin
            lane_sh   = {addr_q[1:0], 3'b000};
            lane_mask = 32'h0000_00FF << lane_sh;
         end
         default: begin
            acc_err = 1'b1;
         end
      endcase

      lane_word = rd_word >> lane_sh;
      case (width_q)
         W_HALF:  load_data = {{16{extend_q & lane_word[15]}}, lane_word[15:0]};
         W_BYTE:  load_data = {{24{extend_q & lane_word[7]}}, lane_word[7:0]};
         default: load_data = lane_word;
      endcase

      wr_word = (rd_word & ~lane_mask) | ((wd_q << lane_sh) & lane_mask);
      mem_we  = (state_q == S_BUSY) && (cnt_q == 4'd0) && we_q && !acc_err;
   end

   // Next-state logic: accept in IDLE, count down in BUSY, one-cycle response in RESP.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      width_d    = width_q;
      extend_d   = extend_q;
      wd_d       = wd_q;
      resp_rd_d  = resp_rd_q;
      resp_err_d = resp_err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d     = req_we;
               addr_d   = req_addr[ADDR_WIDTH+1:0];
               width_d  = req_width;
               extend_d = req_extend;
               wd_d     = req_wd;
               cnt_d    = CNT_INIT;
               state_d  = S_BUSY;
            end
         end
         S_BUSY: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               resp_err_d = acc_err;
               resp_rd_d  = (acc_err || we_q) ? 32'h0 : load_data;
               state_d    = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control and response registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         width_q    <= 2'b00;
         extend_q   <= 1'b0;
         wd_q       <= 32'h0;
         resp_rd_q  <= 32'h0;
         resp_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         width_q    <= width_d;
         extend_q   <= extend_d;
         wd_q       <= wd_d;
         resp_rd_q  <= resp_rd_d;
         resp_err_q <= resp_err_d;
      end
   end

   // Word RAM: cleared on reset, read-modify-write committed on the final BUSY edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= 32'h0;
         end
      end else if (mem_we) begin
         mem[word_idx] <= wr_word;
      end
   end

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - directed self-checking bench for dm_responder
module tb_dm_responder;

   localparam int LAT = 2;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [1:0]  req_width;
   logic        req_extend;
   logic [31:0] req_wd;
   logic        resp_valid;
   logic [31:0] resp_rd;
   logic        resp_err;

   int tests = 0;
   int fails = 0;

   dm_responder #(
      .ADDR_WIDTH(12),
      .LATENCY   (LAT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_width (req_width),
      .req_extend(req_extend),
      .req_wd    (req_wd),
      .resp_valid(resp_valid),
      .resp_rd   (resp_rd),
      .resp_err  (resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                         input logic [1:0] w, input logic ext, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
      int n;
      int low;
      @(negedge clk);
      chk({tag, " ready_before"}, {31'b0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_addr   = addr;
      req_width  = w;
      req_extend = ext;
      req_wd     = wd;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_we     = ~we;
      req_addr   = 32'hFFFF_FFFF;
      req_width  = 2'b10;
      req_extend = ~ext;
      req_wd     = ~wd;
      n   = 0;
      low = 0;
      while (resp_valid !== 1'b1 && n < 20) begin
         if (req_ready === 1'b0) low++;
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, " latency"}, 32'(n), 32'(LAT));
      chk({tag, " rd"}, resp_rd, exp_rd);
      chk({tag, " err"}, {31'b0, resp_err}, {31'b0, exp_err});
      if (req_ready === 1'b0) low++;
      @(posedge clk);
      #1;
      chk({tag, " valid_pulse_end"}, {31'b0, resp_valid}, 32'd0);
      chk({tag, " ready_low_cycles"}, 32'(low), 32'(LAT + 1));
      chk({tag, " ready_after"}, {31'b0, req_ready}, 32'd1);
      chk({tag, " rd_hold"}, resp_rd, exp_rd);
   endtask

   initial begin
      int saw;
      int cnt;
      int first;
      int second;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_addr   = 32'h0;
      req_width  = 2'b00;
      req_extend = 1'b0;
      req_wd     = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("reset ready", {31'b0, req_ready}, 32'd1);
      chk("reset valid", {31'b0, resp_valid}, 32'd0);
      chk("reset rd", resp_rd, 32'h0);
      chk("reset err", {31'b0, resp_err}, 32'd0);

      do_req("st_w_10", 1'b1, 32'h0000_0010, 2'b00, 1'b0, 32'h1234_5678, 32'h0, 1'b0);
      do_req("ld_w_10", 1'b0, 32'h0000_0010, 2'b00, 1'b0, 32'h0, 32'h1234_5678, 1'b0);
      do_req("st_b_11", 1'b1, 32'h0000_0011, 2'b10, 1'b0, 32'hFFFF_FF9A, 32'h0, 1'b0);
      do_req("ld_w_10b", 1'b0, 32'h0000_0010, 2'b00, 1'b1, 32'h0, 32'h1234_9A78, 1'b0);
      do_req("ld_b_11s", 1'b0, 32'h0000_0011, 2'b10, 1'b1, 32'h0, 32'hFFFF_FF9A, 1'b0);
      do_req("ld_b_11z", 1'b0, 32'h0000_0011, 2'b10, 1'b0, 32'h0, 32'h0000_009A, 1'b0);
      do_req("st_h_22", 1'b1, 32'h0000_0022, 2'b01, 1'b0, 32'h0000_8001, 32'h0, 1'b0);
      do_req("ld_h_22s", 1'b0, 32'h0000_0022, 2'b01, 1'b1, 32'h0, 32'hFFFF_8001, 1'b0);
      do_req("ld_h_22z", 1'b0, 32'h0000_0022, 2'b01, 1'b0, 32'h0, 32'h0000_8001, 1'b0);
      do_req("ld_w_20", 1'b0, 32'h0000_0020, 2'b00, 1'b0, 32'h0, 32'h8001_0000, 1'b0);
      do_req("err_ld_w_13", 1'b0, 32'h0000_0013, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
      do_req("err_st_h_21", 1'b1, 32'h0000_0021, 2'b01, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b1);
      do_req("err_w11", 1'b0, 32'h0000_0020, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1);
      do_req("ld_w_20_after_err", 1'b0, 32'h0000_0020, 2'b00, 1'b0, 32'h0, 32'h8001_0000, 1'b0);
      do_req("st_w_4000", 1'b1, 32'h0000_4000, 2'b00, 1'b0, 32'hA5A5_1234, 32'h0, 1'b0);
      do_req("ld_w_0_wrap", 1'b0, 32'h0000_0000, 2'b00, 1'b0, 32'h0, 32'hA5A5_1234, 1'b0);
      do_req("ld_b_3s", 1'b0, 32'h0000_0003, 2'b10, 1'b1, 32'h0, 32'hFFFF_FFA5, 1'b0);

      // Store accepted, then reset one cycle later: no response, store abandoned.
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_addr   = 32'h0000_0040;
      req_width  = 2'b00;
      req_extend = 1'b0;
      req_wd     = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_busy ready", {31'b0, req_ready}, 32'd1);
      saw = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (resp_valid === 1'b1) saw++;
      end
      chk("rst_busy no_resp", 32'(saw), 32'd0);
      do_req("ld_w_40_after_rst", 1'b0, 32'h0000_0040, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
      do_req("ld_w_10_cleared", 1'b0, 32'h0000_0010, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);

      // req_valid held high: one accept every LAT+2 cycles.
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_addr   = 32'h0000_0010;
      req_width  = 2'b00;
      req_extend = 1'b0;
      cnt    = 0;
      first  = -1;
      second = -1;
      for (int c = 0; c < 4 * (LAT + 2); c++) begin
         if (req_ready === 1'b1) begin
            cnt++;
            if (first < 0) first = c;
            else if (second < 0) second = c;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      chk("b2b accepts", 32'(cnt), 32'd4);
      chk("b2b spacing", 32'(second - first), 32'(LAT + 2));
      repeat (LAT + 3) @(posedge clk);
      #1;
      chk("b2b idle", {31'b0, req_ready}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dm_responder.md
# dm_responder

Multi-cycle data-memory responder serving the load/store requests issued by the MEM pipeline stage. Accepts one request at a time over a valid/ready handshake, waits a fixed number of access cycles, then commits the store or returns the sized, extended load data with a one-cycle response pulse. Sits between the MEM stage and the word-organised data RAM, replacing the single-cycle data memory when realistic access latency is modelled.

## Interface

- ADDR_WIDTH, 12, number of word-index bits; RAM depth is 2^ADDR_WIDTH 32-bit words.
- LATENCY, 2, access wait cycles spent in BUSY; legal range 1..15.

- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_width  input  2  00 word, 01 halfword, 10 byte, 11 reserved.
- req_extend  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_wd  input  32  store data; the low byte or halfword is used for narrow stores.
- resp_valid  output  1  one-cycle pulse: response is valid.
- resp_rd  output  32  load result; 0 for stores and errors.
- resp_err  output  1  with resp_valid: request was misaligned or used a reserved width.

## Operation

- States: IDLE, BUSY, RESP. The responder resets to IDLE.
- IDLE: req_ready=1. When req_valid is high at an edge, the responder latches we, addr, width, extend and wd, loads cnt=LATENCY-1, and moves to BUSY.
- BUSY: req_ready=0. When cnt≠0 at an edge, cnt decrements. When cnt==0 at an edge, the responder:
  - performs the access,
  - registers resp_rd and resp_err,
  - moves to RESP.
- RESP: resp_valid=1 for this one cycle. The next edge returns to IDLE. There is no response backpressure.
- Address mapping:
  - Word index = addr[ADDR_WIDTH+1:2]. Higher address bits are ignored, so out-of-range addresses wrap.
  - Byte lanes are little-endian: addr[1:0]=0 selects bits 7:0; addr[1]=0 selects halfword bits 15:0.
- Errors:
  - A halfword request with addr[0]=1 is an error.
  - A word request with addr[1:0]≠0 is an error.
  - width=11 is an error.
  - On an error the responder makes no RAM write, drives resp_rd=0 and resp_err=1, with the same latency as a normal access.
- Store:
  - Read-modify-write of the addressed word; only the selected byte or halfword lanes change.
  - resp_rd=0, resp_err=0.
- Load:
  - The selected lane is right-justified into resp_rd.
  - Bits above the lane are filled with the lane MSB if extend=1, or with 0 if extend=0.
  - A word load ignores extend.
- RAM contents: all words are cleared to 0 on reset.
- Inputs are sampled only at the accepting edge. Changes to inputs while the responder is in BUSY or RESP have no effect.

## Timing

- Reset values: req_ready=1 in IDLE after reset, resp_valid=0, resp_rd=0, resp_err=0, cnt=0.
- With the accepting edge as E0:
  - BUSY occupies the cycles between E0 and E0+LATENCY.
  - The RAM write and response registration happen at edge E0+LATENCY.
  - resp_valid is high between E0+LATENCY and E0+LATENCY+1.
  - req_ready is high again after E0+LATENCY+1.
- Throughput: one request per LATENCY+2 cycles when back-to-back.
- A load issued directly after a store to the same word returns the updated data, because the write commits before the next accept.
- Reset asserted during BUSY or RESP:
  - the state returns to IDLE,
  - a pending store is abandoned (RAM is cleared anyway),
  - resp_valid is 0 in the following cycle.
- resp_rd and resp_err hold their values outside RESP. Only resp_valid qualifies them.

## Test plan

- Reset, then word store addr=0x0000_0010, wd=0x1234_5678, then word load of the same address → resp_rd=0x1234_5678, resp_err=0. resp_valid rises exactly LATENCY edges after each accept; req_ready is low for LATENCY+1 cycles.
- Byte store addr=0x11, wd=0xFFFF_FF9A onto the word above → word at 0x10 becomes 0x1234_9A78. Byte load of 0x11 returns 0xFFFF_FF9A with extend=1 and 0x0000_009A with extend=0.
- Halfword store addr=0x22, wd=0x0000_8001, then halfword loads of 0x22 → 0xFFFF_8001 with sign extension and 0x0000_8001 with zero extension. Word load of 0x20 → 0x8001_0000.
- Misaligned requests: word load 0x13, halfword store 0x21 with wd=0xDEAD_BEEF, and a load with width=11 → each gives resp_err=1, resp_rd=0. A follow-up word load of 0x20 still returns 0x8001_0000.
- Wrap-around with ADDR_WIDTH=12: word store to 0x0000_4000 → a word load of 0x0 returns the same data.
- Reset asserted one cycle after accepting a word store of 0xCAFE_F00D to 0x40 → resp_valid never pulses, and a later load of 0x40 returns 0. req_valid held high continuously through the sequence → exactly one accept every LATENCY+2 cycles.
